// File: rtl/sha_wb_fifo_ctrl.sv
// Wishbone front-end for a SHA-256 engine: message FIFO with core backpressure,
// sticky overflow, auto-incrementing digest readout and a maskable done interrupt.
module sha_wb_fifo_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int HASH_WORDS = 8,
    parameter int DW         = 32
) (
    input  logic            CLK_I,
    input  logic            RST_N_I,
    input  logic            SHA_STB_I,
    input  logic            SHA_WE_I,
    input  logic [4:0]      SHA_ADR_I,
    input  logic [DW-1:0]   SHA_DAT_I,
    output logic            SHA_ACK_O,
    output logic            SHA_ERR_O,
    output logic [DW-1:0]   SHA_DAT_O,
    output logic            SHA_IRQ_O,
    output logic            core_init,
    output logic            core_vld,
    output logic [DW-1:0]   core_din,
    output logic [8*DW-1:0] core_h,
    input  logic            core_rdy,
    input  logic            core_done,
    input  logic [8*DW-1:0] core_hash
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [2:0] HASH_LAST = 3'(HASH_WORDS - 1);
    localparam logic [255:0] SHA256_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [4:0] A_CMD  = 5'h00;
    localparam logic [4:0] A_DIN  = 5'h04;
    localparam logic [4:0] A_HASH = 5'h08;
    localparam logic [4:0] A_HI   = 5'h0C;
    localparam logic [4:0] A_IRQ  = 5'h10;

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, level;
    logic          full, empty;
    logic          done, ovf, irq_en, irq_pend;
    logic [2:0]    hash_ptr;
    logic [DW-1:0] status, rd_data;
    logic [DW-1:0] hash_w [8];

    // An access is taken only on the first STB cycle, before ACK/ERR answers it
    logic acc, wr_acc, rd_acc;
    logic cmd_wr, din_wr, hi_wr, irq_wr, hash_rd;
    logic init, push, pop, ovf_set;

    assign acc     = SHA_STB_I & ~SHA_ACK_O & ~SHA_ERR_O;
    assign wr_acc  = acc & SHA_WE_I;
    assign rd_acc  = acc & ~SHA_WE_I;
    assign cmd_wr  = wr_acc && (SHA_ADR_I == A_CMD);
    assign din_wr  = wr_acc && (SHA_ADR_I == A_DIN);
    assign hi_wr   = wr_acc && (SHA_ADR_I == A_HI);
    assign irq_wr  = wr_acc && (SHA_ADR_I == A_IRQ);
    assign hash_rd = rd_acc && (SHA_ADR_I == A_HASH);

    assign init    = cmd_wr & SHA_DAT_I[0];
    assign push    = din_wr & ~full;
    assign ovf_set = din_wr & full;
    assign pop     = ~empty & core_rdy & ~core_init;

    assign level = wr_ptr - rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign SHA_IRQ_O = irq_pend & irq_en;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            hash_w[i] = core_hash[DW*(7-i) +: DW];
        end
    end

    always_comb begin
        status             = '0;
        status[1]          = done;
        status[2]          = ovf;
        status[4]          = irq_en;
        status[5]          = full;
        status[6]          = empty;
        status[7]          = irq_pend;
        status[8 +: AW+1]  = level;
    end

    always_comb begin
        rd_data = '0;
        case (SHA_ADR_I)
            A_CMD:   rd_data = status;
            A_HASH:  rd_data = hash_w[hash_ptr];
            A_IRQ:   rd_data = DW'(irq_pend);
            default: rd_data = '0;
        endcase
    end

    // Message storage carries no reset; the pointers define what is valid
    always_ff @(posedge CLK_I) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= SHA_DAT_I;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            irq_en    <= 1'b0;
            irq_pend  <= 1'b0;
            hash_ptr  <= '0;
            SHA_ACK_O <= 1'b0;
            SHA_ERR_O <= 1'b0;
            SHA_DAT_O <= '0;
            core_init <= 1'b0;
            core_vld  <= 1'b0;
            core_din  <= '0;
            core_h    <= SHA256_IV;
        end else begin
            SHA_ACK_O <= acc & ~ovf_set;
            SHA_ERR_O <= ovf_set;
            SHA_DAT_O <= rd_acc ? rd_data : '0;
            core_init <= init;
            core_vld  <= pop;
            if (pop) begin
                core_din <= mem[rd_ptr[AW-1:0]];
            end

            if (init) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end

            if (init || push) done <= 1'b0;
            if (core_done)    done <= 1'b1;

            if (init)         ovf <= 1'b0;
            else if (ovf_set) ovf <= 1'b1;

            if (cmd_wr) irq_en <= SHA_DAT_I[4];

            // A completion landing with a software clear keeps the interrupt pending
            if (core_done)                    irq_pend <= 1'b1;
            else if (irq_wr && SHA_DAT_I[0])  irq_pend <= 1'b0;

            if (init)         hash_ptr <= '0;
            else if (hash_rd) hash_ptr <= (hash_ptr == HASH_LAST) ? 3'd0 : hash_ptr + 3'd1;

            if (cmd_wr && SHA_DAT_I[2]) core_h <= SHA256_IV;
            else if (hi_wr)             core_h <= {core_h[8*DW-DW-1:0], SHA_DAT_I};
        end
    end
endmodule

// File: tb/tb_sha_wb_fifo_ctrl.sv
// Directed bench for sha_wb_fifo_ctrl; core words are tracked through a scoreboard queue.
module tb_sha_wb_fifo_ctrl;
    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    logic         CLK_I = 1'b0;
    logic         RST_N_I;
    logic         stb, stb7, we;
    logic [4:0]   adr;
    logic [31:0]  wdat;
    logic         core_rdy, core_done;
    logic [255:0] core_hash;

    logic         ack, err, irq, core_init, core_vld;
    logic [31:0]  rdat, core_din;
    logic [255:0] core_h;
    logic         ack7, err7, irq7, core_init7, core_vld7;
    logic [31:0]  rdat7, core_din7;
    logic [255:0] core_h7;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    int vld_cnt = 0, first_vld = 0, last_vld = 0, cyc = 0;
    logic init_seen;

    sha_wb_fifo_ctrl #(.FIFO_DEPTH(16), .HASH_WORDS(8), .DW(32)) dut (
        .CLK_I(CLK_I), .RST_N_I(RST_N_I), .SHA_STB_I(stb), .SHA_WE_I(we),
        .SHA_ADR_I(adr), .SHA_DAT_I(wdat), .SHA_ACK_O(ack), .SHA_ERR_O(err),
        .SHA_DAT_O(rdat), .SHA_IRQ_O(irq), .core_init(core_init), .core_vld(core_vld),
        .core_din(core_din), .core_h(core_h), .core_rdy(core_rdy), .core_done(core_done),
        .core_hash(core_hash)
    );

    sha_wb_fifo_ctrl #(.FIFO_DEPTH(16), .HASH_WORDS(7), .DW(32)) dut7 (
        .CLK_I(CLK_I), .RST_N_I(RST_N_I), .SHA_STB_I(stb7), .SHA_WE_I(we),
        .SHA_ADR_I(adr), .SHA_DAT_I(wdat), .SHA_ACK_O(ack7), .SHA_ERR_O(err7),
        .SHA_DAT_O(rdat7), .SHA_IRQ_O(irq7), .core_init(core_init7), .core_vld(core_vld7),
        .core_din(core_din7), .core_h(core_h7), .core_rdy(core_rdy), .core_done(core_done),
        .core_hash(core_hash)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every word leaving the FIFO is compared with the oldest word pushed
    always @(negedge CLK_I) begin
        cyc++;
        if (core_vld === 1'b1) begin
            vld_cnt++;
            if (vld_cnt == 1) first_vld = cyc;
            last_vld = cyc;
            if (exp_q.size() == 0) check("core_vld_unexpected", 256'(core_vld), 256'(0));
            else                   check("core_din", 256'(core_din), 256'(exp_q.pop_front()));
        end
    end

    task automatic bus(input bit d7, input bit w, input logic [4:0] a, input logic [31:0] d,
                       input bit exp_err, input bit pulse, output logic [31:0] rd);
        int n;
        logic r_ack, r_err;
        @(negedge CLK_I);
        we = w; adr = a; wdat = d;
        if (d7) stb7 = 1'b1; else stb = 1'b1;
        if (pulse) core_done = 1'b1;
        n = 0;
        do begin
            @(negedge CLK_I);
            core_done = 1'b0;
            n++;
            r_ack = d7 ? ack7 : ack;
            r_err = d7 ? err7 : err;
        end while (!(r_ack | r_err) && n < 10);
        rd = d7 ? rdat7 : rdat;
        init_seen = core_init;
        stb = 1'b0; stb7 = 1'b0; we = 1'b0;
        check("bus_resp", 256'({r_ack, r_err}), exp_err ? 256'(2'b01) : 256'(2'b10));
        @(negedge CLK_I);
        check("bus_release", 256'(d7 ? {ack7, err7} : {ack, err}), 256'(0));
    endtask

    task automatic wr(input bit d7, input logic [4:0] a, input logic [31:0] d, input bit exp_err);
        logic [31:0] v;
        bus(d7, 1'b1, a, d, exp_err, 1'b0, v);
    endtask

    task automatic rd_chk(input bit d7, input logic [4:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] v;
        bus(d7, 1'b0, a, 32'h0, 1'b0, 1'b0, v);
        check(tag, 256'(v), 256'(exp));
    endtask

    initial begin
        logic [31:0] w32, v;
        logic [255:0] exp_h;
        RST_N_I = 1'b0; stb = 1'b0; stb7 = 1'b0; we = 1'b0; adr = '0; wdat = '0;
        core_rdy = 1'b0; core_done = 1'b0; core_hash = '0;
        for (int i = 0; i < 8; i++) core_hash[255-32*i -: 32] = 32'(32'h11111111 * i);
        repeat (3) @(negedge CLK_I);
        RST_N_I = 1'b1;

        // Reset state
        @(negedge CLK_I);
        check("rst_irq", 256'(irq), 256'(0));
        check("rst_core_h", core_h, IV);
        check("rst_vld_init", 256'({core_vld, core_init}), 256'(0));
        rd_chk(1'b0, 5'h00, 32'h0000_0040, "rst_status");
        rd_chk(1'b0, 5'h14, 32'h0, "unmapped_rd");
        rd_chk(1'b0, 5'h0C, 32'h0, "hi_rd_zero");

        // Fill to full with the core stalled, then overflow
        for (int i = 0; i < 16; i++) begin
            w32 = $urandom;
            exp_q.push_back(w32);
            wr(1'b0, 5'h04, w32, 1'b0);
        end
        check("stall_no_vld", 256'(vld_cnt), 256'(0));
        rd_chk(1'b0, 5'h00, 32'h0000_1020, "status_full");
        wr(1'b0, 5'h04, 32'hDEAD_BEEF, 1'b1);
        rd_chk(1'b0, 5'h00, 32'h0000_1024, "status_ovf");

        // Drain back-to-back
        core_rdy = 1'b1;
        repeat (20) @(negedge CLK_I);
        check("drain_cnt", 256'(vld_cnt), 256'(16));
        check("drain_b2b", 256'(last_vld - first_vld), 256'(15));
        check("drain_q_empty", 256'(exp_q.size()), 256'(0));
        check("drain_vld_low", 256'(core_vld), 256'(0));
        rd_chk(1'b0, 5'h00, 32'h0000_0044, "status_drained");

        // Completion interrupt and digest readout with wrap
        wr(1'b0, 5'h00, 32'h10, 1'b0);
        @(negedge CLK_I); core_done = 1'b1;
        @(negedge CLK_I); core_done = 1'b0;
        check("irq_on_done", 256'(irq), 256'(1));
        rd_chk(1'b0, 5'h00, 32'h0000_00D6, "status_done");
        for (int i = 0; i < 8; i++) rd_chk(1'b0, 5'h08, 32'(32'h11111111 * i), "hash_rd");
        rd_chk(1'b0, 5'h08, 32'h0, "hash_wrap8");

        // SHA-224 readout wraps after seven words
        for (int i = 0; i < 7; i++) rd_chk(1'b1, 5'h08, 32'(32'h11111111 * i), "hash7_rd");
        rd_chk(1'b1, 5'h08, 32'h0, "hash_wrap7");

        // Clear colliding with completion keeps the interrupt; a lone clear drops it
        bus(1'b0, 1'b1, 5'h10, 32'h1, 1'b0, 1'b1, v);
        rd_chk(1'b0, 5'h10, 32'h1, "irq_set_wins");
        check("irq_out_set_wins", 256'(irq), 256'(1));
        wr(1'b0, 5'h10, 32'h1, 1'b0);
        rd_chk(1'b0, 5'h10, 32'h0, "irq_cleared");
        check("irq_out_cleared", 256'(irq), 256'(0));

        // Init flushes queued words
        core_rdy = 1'b0;
        for (int i = 0; i < 5; i++) wr(1'b0, 5'h04, 32'hC000_0000 + 32'(i), 1'b0);
        rd_chk(1'b0, 5'h00, 32'h0000_0514, "status_5");
        bus(1'b0, 1'b1, 5'h00, 32'h1, 1'b0, 1'b0, v);
        check("init_pulse", 256'(init_seen), 256'(1));
        check("init_one_cycle", 256'(core_init), 256'(0));
        rd_chk(1'b0, 5'h00, 32'h0000_0040, "status_flushed");
        vld_cnt = 0;
        core_rdy = 1'b1;
        repeat (4) @(negedge CLK_I);
        check("flush_no_vld", 256'(vld_cnt), 256'(0));

        // Initial-hash loading and IV reload
        exp_h = '0;
        for (int i = 0; i < 8; i++) begin
            w32 = 32'hA000_0000 + 32'(i);
            exp_h[255-32*i -: 32] = w32;
            wr(1'b0, 5'h0C, w32, 1'b0);
        end
        check("core_h_loaded", core_h, exp_h);
        wr(1'b0, 5'h00, 32'h4, 1'b0);
        check("core_h_iv_reload", core_h, IV);
        wr(1'b0, 5'h0C, 32'h1234_5678, 1'b0);

        // Asynchronous reset in the middle of a drain
        core_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            w32 = $urandom;
            exp_q.push_back(w32);
            wr(1'b0, 5'h04, w32, 1'b0);
        end
        vld_cnt = 0;
        core_rdy = 1'b1;
        @(negedge CLK_I);
        @(negedge CLK_I);
        #2;
        check("burst_partial", 256'(vld_cnt), 256'(2));
        RST_N_I = 1'b0;
        exp_q.delete();
        #1;
        check("async_vld", 256'(core_vld), 256'(0));
        check("async_core_h", core_h, IV);
        check("async_din", 256'(core_din), 256'(0));
        repeat (2) @(negedge CLK_I);
        RST_N_I = 1'b1;
        check("post_rst_vld", 256'(vld_cnt), 256'(2));
        rd_chk(1'b0, 5'h00, 32'h0000_0040, "post_rst_status");
        check("post_rst_irq", 256'(irq), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
